square_wave_ctrl: RTL

//  Programmable square-wave sequencer for the DDS FPGA test-signal path. Holds the

---
 rtl/square_wave_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/square_wave_ctrl.sv
// Programmable square-wave sequencer: high/low phase lengths, optional N-period burst,
// start/stop control, and glitch-free config updates applied only at period boundaries.
module square_wave_ctrl #(
    parameter int          CNT_W    = 32,
    parameter int          BURST_W  = 16,
    parameter int unsigned DEF_HIGH = 2500,
    parameter int unsigned DEF_LOW  = 2500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_high,
    input  logic [CNT_W-1:0]   cfg_low,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               wave_out,
    output logic               busy,
    output logic               period_tick,
    output logic               burst_done,
    output logic               cfg_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BURST_W-1:0] per_q, per_d;
    logic [CNT_W-1:0]   act_high_q, act_high_d;
    logic [CNT_W-1:0]   act_low_q, act_low_d;
    logic [BURST_W-1:0] act_burst_q, act_burst_d;
    logic [CNT_W-1:0]   sh_high_q, sh_high_d;
    logic [CNT_W-1:0]   sh_low_q, sh_low_d;
    logic [BURST_W-1:0] sh_burst_q, sh_burst_d;
    logic               sh_pend_q, sh_pend_d;
    logic               stop_pend_q, stop_pend_d;
    logic               wave_q, wave_d;
    logic               busy_q, busy_d;
    logic               tick_q, tick_d;
    logic               bdone_q, bdone_d;
    logic               err_q, err_d;
    logic               ready_q, ready_d;

    logic               high_end_s;
    logic               low_end_s;
    logic               boundary_s;
    logic               stop_seen_s;
    logic               burst_end_s;
    logic               apply_s;
    logic [BURST_W-1:0] per_inc_s;

    // Phase-end and period-boundary decode against the active lengths
    always_comb begin
        high_end_s  = (cnt_q == (act_high_q - CNT_W'(1)));
        low_end_s   = (cnt_q == (act_low_q - CNT_W'(1)));
        boundary_s  = (state_q == ST_LOW) && low_end_s;
        stop_seen_s = stop_pend_q | stop;
        per_inc_s   = per_q + BURST_W'(1);
        burst_end_s = (act_burst_q != BURST_W'(0)) && (per_inc_s == act_burst_q);
        apply_s     = sh_pend_q && ((state_q == ST_IDLE) || boundary_s);
    end

    // Next-state, counters, config shadow and output decode
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        per_d       = per_q;
        act_high_d  = act_high_q;
        act_low_d   = act_low_q;
        act_burst_d = act_burst_q;
        sh_high_d   = sh_high_q;
        sh_low_d    = sh_low_q;
        sh_burst_d  = sh_burst_q;
        sh_pend_d   = sh_pend_q;
        stop_pend_d = stop_pend_q;
        tick_d      = 1'b0;
        bdone_d     = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d       = '0;
                per_d       = '0;
                stop_pend_d = 1'b0;
                if (start && !stop) begin
                    state_d = ST_HIGH;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HIGH: begin
                stop_pend_d = stop_seen_s;
                if (high_end_s) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_HIGH;
                end
            end
            ST_LOW: begin
                stop_pend_d = stop_seen_s;
                if (low_end_s) begin
                    tick_d  = 1'b1;
                    bdone_d = burst_end_s;
                    cnt_d   = '0;
                    if (stop_seen_s || burst_end_s) begin
                        state_d     = ST_IDLE;
                        per_d       = '0;
                        stop_pend_d = 1'b0;
                    end else begin
                        state_d = ST_HIGH;
                        // a newly applied config restarts burst counting
                        per_d   = sh_pend_q ? BURST_W'(0) : per_inc_s;
                    end
                end else begin
                    state_d = ST_LOW;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                cnt_d       = '0;
                per_d       = '0;
                stop_pend_d = 1'b0;
            end
        endcase

        // cfg_ready is low while a shadow is pending, so accept and apply never coincide
        if (apply_s) begin
            act_high_d  = sh_high_q;
            act_low_d   = sh_low_q;
            act_burst_d = sh_burst_q;
            sh_pend_d   = 1'b0;
        end else if (cfg_valid && ready_q) begin
            if ((cfg_high == CNT_W'(0)) || (cfg_low == CNT_W'(0))) begin
                err_d = 1'b1;
            end else begin
                sh_high_d  = cfg_high;
                sh_low_d   = cfg_low;
                sh_burst_d = cfg_burst;
                sh_pend_d  = 1'b1;
            end
        end else begin
            sh_pend_d = sh_pend_q;
        end

        ready_d = ~sh_pend_d;
        wave_d  = (state_d == ST_HIGH);
        busy_d  = (state_d != ST_IDLE);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath, config and registered output flops
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            per_q       <= '0;
            act_high_q  <= CNT_W'(DEF_HIGH);
            act_low_q   <= CNT_W'(DEF_LOW);
            act_burst_q <= '0;
            sh_high_q   <= '0;
            sh_low_q    <= '0;
            sh_burst_q  <= '0;
            sh_pend_q   <= 1'b0;
            stop_pend_q <= 1'b0;
            wave_q      <= 1'b0;
            busy_q      <= 1'b0;
            tick_q      <= 1'b0;
            bdone_q     <= 1'b0;
            err_q       <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            act_high_q  <= act_high_d;
            act_low_q   <= act_low_d;
            act_burst_q <= act_burst_d;
            sh_high_q   <= sh_high_d;
            sh_low_q    <= sh_low_d;
            sh_burst_q  <= sh_burst_d;
            sh_pend_q   <= sh_pend_d;
            stop_pend_q <= stop_pend_d;
            wave_q      <= wave_d;
            busy_q      <= busy_d;
            tick_q      <= tick_d;
            bdone_q     <= bdone_d;
            err_q       <= err_d;
            ready_q     <= ready_d;
        end
    end

    assign wave_out    = wave_q;
    assign busy        = busy_q;
    assign period_tick = tick_q;
    assign burst_done  = bdone_q;
    assign cfg_err     = err_q;
    assign cfg_ready   = ready_q;

endmodule
